// File: rtl/l1d_package.sv
// Shared L1D types: the data RAM request payload used by the MSHR, the RAM
// scheduler and the data RAM, plus the scheduler's FSM state encoding.
package l1d_package;

    localparam int DATA_RAM_WAY_W  = 2;
    localparam int DATA_RAM_SET_W  = 6;
    localparam int DATA_RAM_DATA_W = 32;

    typedef struct packed {
        logic                       wr_en;
        logic [DATA_RAM_WAY_W-1:0]  way;
        logic [DATA_RAM_SET_W-1:0]  set_idx;
        logic [DATA_RAM_DATA_W-1:0] data;
    } pack_data_ram_req_pld;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } data_ram_sched_state_e;

endpackage

// File: rtl/l1d_data_ram_out_reg.sv
// Single-entry valid/ready pipeline register driving the data RAM request;
// out_free tells the arbiter whether a new request may be loaded this cycle.
module l1d_data_ram_out_reg
    import l1d_package::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    input  pack_data_ram_req_pld in_pld,
    input  logic                 ram_rdy,
    output logic                 ram_vld,
    output pack_data_ram_req_pld ram_pld,
    output logic                 out_free
);

    // The slot is reusable when empty or being drained in this same cycle.
    assign out_free = !ram_vld || ram_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_vld <= 1'b0;
            ram_pld <= '0;
        end else if (in_vld) begin
            ram_vld <= 1'b1;
            ram_pld <= in_pld;
        end else if (ram_rdy) begin
            ram_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/l1d_data_ram_sched.sv
// Data RAM scheduler: fixed-priority arbitration (bps > ent > ld) with refill
// burst locking and a load anti-starvation override, feeding one output register.
module l1d_data_ram_sched
    import l1d_package::*;
#(
    parameter int REFILL_BEATS = 4,
    parameter int STARVE_MAX   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bps_vld,
    output logic                 bps_rdy,
    input  pack_data_ram_req_pld bps_pld,
    input  logic                 ent_vld,
    output logic                 ent_rdy,
    input  pack_data_ram_req_pld ent_pld,
    input  logic                 ld_vld,
    output logic                 ld_rdy,
    input  pack_data_ram_req_pld ld_pld,
    output logic                 ram_vld,
    output pack_data_ram_req_pld ram_pld,
    input  logic                 ram_rdy,
    output logic                 lock_busy
);

    localparam int BEAT_W   = $clog2(REFILL_BEATS);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(REFILL_BEATS - 1);
    localparam logic [STARVE_W-1:0] STARVE_SAT = STARVE_W'(STARVE_MAX);

    // Handshake: a requester transfers in the cycle x_vld && x_rdy; x_rdy is a
    // grant that never depends on any payload and is only raised for a valid.
    data_ram_sched_state_e state_q, state_d;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [STARVE_W-1:0]   starve_cnt;
    logic                  out_free;
    logic                  bps_xfer, ent_xfer, ld_xfer, any_xfer;
    pack_data_ram_req_pld  win_pld;

    assign bps_xfer = bps_vld && bps_rdy;
    assign ent_xfer = ent_vld && ent_rdy;
    assign ld_xfer  = ld_vld  && ld_rdy;
    assign any_xfer = bps_xfer || ent_xfer || ld_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ent_xfer) state_d = LOCK;
            LOCK:    if (ent_xfer && beat_cnt == LAST_BEAT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Saturated starvation only overrides priority outside a refill lock.
    always_comb begin
        bps_rdy   = 1'b0;
        ent_rdy   = 1'b0;
        ld_rdy    = 1'b0;
        lock_busy = (state_q == LOCK);
        if (out_free) begin
            if (state_q == LOCK) begin
                ent_rdy = ent_vld;
            end else if (ld_vld && starve_cnt == STARVE_SAT) begin
                ld_rdy = 1'b1;
            end else if (bps_vld) begin
                bps_rdy = 1'b1;
            end else if (ent_vld) begin
                ent_rdy = 1'b1;
            end else begin
                ld_rdy = ld_vld;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (ent_xfer) begin
            beat_cnt <= (state_q == LOCK && beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (ld_xfer || !ld_vld) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_SAT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        win_pld = ld_pld;
        if (bps_xfer)      win_pld = bps_pld;
        else if (ent_xfer) win_pld = ent_pld;
    end

    l1d_data_ram_out_reg u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (any_xfer),
        .in_pld   (win_pld),
        .ram_rdy  (ram_rdy),
        .ram_vld  (ram_vld),
        .ram_pld  (ram_pld),
        .out_free (out_free)
    );

endmodule

// File: tb/tb_l1d_data_ram_sched.sv
// Bench for l1d_data_ram_sched: directed scenarios with literal expectations,
// a cycle-level reference model and an in-order payload scoreboard.
module tb_l1d_data_ram_sched;
    import l1d_package::*;

    localparam int REFILL_BEATS = 4;
    localparam int STARVE_MAX   = 8;
    localparam int PLD_W        = $bits(pack_data_ram_req_pld);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bps_vld = 1'b0, ent_vld = 1'b0, ld_vld = 1'b0, ram_rdy = 1'b1;
    logic bps_rdy, ent_rdy, ld_rdy, ram_vld, lock_busy;
    pack_data_ram_req_pld bps_pld = '0, ent_pld = '0, ld_pld = '0, ram_pld;

    int n_chk = 0;
    int n_pass = 0;
    int bps_grants = 0;

    // model state
    bit                   m_vld;
    pack_data_ram_req_pld m_pld;
    bit                   m_lock;
    int                   m_beats;
    int                   m_starve;
    logic [PLD_W-1:0]     exp_q[$];

    l1d_data_ram_sched #(
        .REFILL_BEATS (REFILL_BEATS),
        .STARVE_MAX   (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bps_vld   (bps_vld),
        .bps_rdy   (bps_rdy),
        .bps_pld   (bps_pld),
        .ent_vld   (ent_vld),
        .ent_rdy   (ent_rdy),
        .ent_pld   (ent_pld),
        .ld_vld    (ld_vld),
        .ld_rdy    (ld_rdy),
        .ld_pld    (ld_pld),
        .ram_vld   (ram_vld),
        .ram_pld   (ram_pld),
        .ram_rdy   (ram_rdy),
        .lock_busy (lock_busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: act=%0h req=%0h t=%0t", name, act, exp, $time);
    endtask

    function automatic pack_data_ram_req_pld mk(input int kind, input int n);
        pack_data_ram_req_pld p;
        p.wr_en   = (kind != 2);
        p.way     = kind[1:0];
        p.set_idx = n[5:0];
        p.data    = 32'hA000_0000 | (kind << 16) | n;
        return p;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the given requester to transfer, then steps past the edge.
    task automatic wait_xfer(input int k, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            case (k)
                1:       got = bps_vld && bps_rdy;
                2:       got = ent_vld && ent_rdy;
                default: got = ld_vld && ld_rdy;
            endcase
        end
        chk({name, "_xfer_timeout"}, 64'(got), 64'd1);
        cyc();
    endtask

    task automatic burst(input int first, input int last, input int gap);
        for (int b = first; b < last; b++) begin
            ent_vld = 1'b1;
            ent_pld = mk(1, b);
            wait_xfer(2, "ent");
            ent_vld = 1'b0;
            if (b < last - 1) repeat (gap) cyc();
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    always @(negedge clk) begin
        int win;
        bit free;
        pack_data_ram_req_pld wp;
        logic [PLD_W-1:0] e;
        if (!rst_n) begin
            m_vld = 1'b0; m_pld = '0; m_lock = 1'b0; m_beats = 0; m_starve = 0;
            exp_q.delete();
            chk("rst_ram_vld", 64'(ram_vld), 64'd0);
            chk("rst_lock_busy", 64'(lock_busy), 64'd0);
        end else begin
            free = !m_vld || ram_rdy;
            win  = 0;
            if (free) begin
                if (m_lock) begin
                    if (ent_vld) win = 2;
                end else if (m_starve == STARVE_MAX && ld_vld) win = 3;
                else if (bps_vld) win = 1;
                else if (ent_vld) win = 2;
                else if (ld_vld)  win = 3;
            end
            chk("bps_rdy", 64'(bps_rdy), 64'(win == 1));
            chk("ent_rdy", 64'(ent_rdy), 64'(win == 2));
            chk("ld_rdy", 64'(ld_rdy), 64'(win == 3));
            chk("ram_vld", 64'(ram_vld), 64'(m_vld));
            chk("ram_pld", 64'(ram_pld), 64'(m_pld));
            chk("lock_busy", 64'(lock_busy), 64'(m_lock));
            chk("starve_cnt", 64'(dut.starve_cnt), 64'(m_starve));
            chk("beat_cnt", 64'(dut.beat_cnt), 64'(m_beats));
            if (ram_vld && ram_rdy) begin
                if (exp_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_ram_pld", 64'(ram_pld), 64'(e));
                end
            end
            if (bps_vld && bps_rdy) bps_grants++;
            if (win != 0) begin
                wp = (win == 1) ? bps_pld : (win == 2) ? ent_pld : ld_pld;
                m_vld = 1'b1;
                m_pld = wp;
                exp_q.push_back(wp);
            end else if (ram_rdy) begin
                m_vld = 1'b0;
            end
            if (win == 2) begin
                m_beats++;
                if (m_beats == REFILL_BEATS) begin
                    m_beats = 0;
                    m_lock  = 1'b0;
                end else begin
                    m_lock = 1'b1;
                end
            end
            if (win == 3 || !ld_vld) m_starve = 0;
            else if (m_starve < STARVE_MAX) m_starve++;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int hit;
        int g0;
        #1;
        chk("por_ram_vld", 64'(ram_vld), 64'd0);
        chk("por_ram_pld", 64'(ram_pld), 64'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();

        // reset and priority
        bps_vld = 1'b1; bps_pld = mk(0, 0);
        ent_vld = 1'b1; ent_pld = mk(1, 0);
        ld_vld  = 1'b1; ld_pld  = mk(2, 0);
        @(negedge clk);
        chk("prio_bps_rdy", 64'(bps_rdy), 64'd1);
        chk("prio_ent_rdy", 64'(ent_rdy), 64'd0);
        chk("prio_ld_rdy", 64'(ld_rdy), 64'd0);
        cyc();
        bps_vld = 1'b0;
        @(negedge clk);
        chk("prio_ram_pld_bps", 64'(ram_pld), 64'(mk(0, 0)));
        chk("prio_ent_next", 64'(ent_rdy), 64'd1);
        cyc();
        ent_pld = mk(1, 1);
        #3;
        chk("prio_lock_busy", 64'(lock_busy), 64'd1);
        burst(1, REFILL_BEATS, 0);
        wait_xfer(3, "ld");
        ld_vld = 1'b0;
        repeat (2) cyc();

        // refill lock with gaps while bps waits
        ent_vld = 1'b1; ent_pld = mk(1, 10);
        wait_xfer(2, "ent");
        bps_vld = 1'b1; bps_pld = mk(0, 20);
        ent_vld = 1'b0;
        g0 = bps_grants;
        cyc();
        burst(11, 14, 1);
        chk("lock_bps_blocked", 64'(bps_grants - g0), 64'd0);
        @(negedge clk);
        chk("lock_bps_after", 64'(bps_rdy), 64'd1);
        chk("lock_released", 64'(lock_busy), 64'd0);
        cyc();
        bps_vld = 1'b0;
        repeat (2) cyc();

        // load starvation
        bps_vld = 1'b1; bps_pld = mk(0, 30);
        ld_vld  = 1'b1; ld_pld  = mk(2, 31);
        hit = 0;
        for (int i = 1; i <= 20 && hit == 0; i++) begin
            @(negedge clk);
            if (ld_rdy) hit = i;
        end
        cyc();
        chk("starve_grant_cycle", 64'(hit), 64'd9);
        #2;
        chk("starve_cleared", 64'(dut.starve_cnt), 64'd0);
        chk("starve_bps_resumes", 64'(bps_rdy), 64'd1);
        cyc();
        bps_vld = 1'b0;
        wait_xfer(3, "ld");
        ld_vld = 1'b0;
        repeat (2) cyc();

        // backpressure
        ram_rdy = 1'b0;
        bps_vld = 1'b1; bps_pld = mk(0, 40);
        ld_vld  = 1'b1; ld_pld  = mk(2, 41);
        cyc();
        bps_pld = mk(0, 42);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("bp_ram_pld_hold", 64'(ram_pld), 64'(mk(0, 40)));
            chk("bp_rdys_low", 64'({bps_rdy, ent_rdy, ld_rdy}), 64'd0);
            chk("bp_starve_count", 64'(dut.starve_cnt), 64'(k));
            cyc();
        end
        ram_rdy = 1'b1;
        @(negedge clk);
        chk("bp_same_cycle_grant", 64'(bps_rdy), 64'd1);
        cyc();
        bps_vld = 1'b0;
        wait_xfer(3, "ld");
        ld_vld = 1'b0;
        repeat (2) cyc();

        // starvation saturates during a refill lock
        ld_vld  = 1'b1; ld_pld  = mk(2, 50);
        ent_vld = 1'b1; ent_pld = mk(1, 60);
        wait_xfer(2, "ent");
        bps_vld = 1'b1; bps_pld = mk(0, 51);
        ent_vld = 1'b0;
        repeat (2) cyc();
        burst(61, 64, 2);
        @(negedge clk);
        chk("sl_ld_wins", 64'(ld_rdy), 64'd1);
        chk("sl_bps_waits", 64'(bps_rdy), 64'd0);
        chk("sl_unlocked", 64'(lock_busy), 64'd0);
        cyc();
        ld_vld = 1'b0;
        wait_xfer(1, "bps");
        bps_vld = 1'b0;
        repeat (2) cyc();

        // reset in the middle of a burst
        ld_vld  = 1'b1; ld_pld  = mk(2, 70);
        ent_vld = 1'b1; ent_pld = mk(1, 80);
        wait_xfer(2, "ent");
        burst(81, 82, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_ram_vld", 64'(ram_vld), 64'd0);
        chk("mr_ram_pld", 64'(ram_pld), 64'd0);
        chk("mr_lock_busy", 64'(lock_busy), 64'd0);
        chk("mr_beat_cnt", 64'(dut.beat_cnt), 64'd0);
        chk("mr_starve_cnt", 64'(dut.starve_cnt), 64'd0);
        ld_vld = 1'b0;
        ent_vld = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cyc();
        bps_vld = 1'b1; bps_pld = mk(0, 90);
        @(negedge clk);
        chk("mr_bps_grant", 64'(bps_rdy), 64'd1);
        cyc();
        bps_vld = 1'b0;
        @(negedge clk);
        chk("mr_bps_out", 64'(ram_pld), 64'(mk(0, 90)));
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/l1d_data_ram_sched.md
# l1d_data_ram_sched

Sequencing arbiter in front of the L1D single-port data RAM. Shares the RAM among three requesters: MSHR bypass writes, MSHR refill bursts and core load reads. Applies fixed priority with refill-burst locking and load anti-starvation. Presents one registered request per cycle to the RAM under a valid/ready handshake.

## Interface
- `REFILL_BEATS`, 4: beats per refill burst (power of two, ≥2).
- `STARVE_MAX`, 8: consecutive denied cycles after which the load requester is forced to win (≥1).
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous active-low reset.
- `bps_vld` / `bps_rdy` input/output 1: MSHR bypass request handshake.
- `bps_pld` input `pack_data_ram_req_pld`: bypass payload.
- `ent_vld` / `ent_rdy` input/output 1: MSHR refill beat handshake.
- `ent_pld` input `pack_data_ram_req_pld`: refill beat payload.
- `ld_vld` / `ld_rdy` input/output 1: core load read handshake.
- `ld_pld` input `pack_data_ram_req_pld`: load payload.
- `ram_vld` output 1: registered request to the data RAM.
- `ram_pld` output `pack_data_ram_req_pld`: registered RAM payload.
- `ram_rdy` input 1: RAM accepts `ram_vld` this cycle.
- `lock_busy` output 1: refill burst in progress (state LOCK).

## Operation
- Output stage: `out_free = !ram_vld || ram_rdy`. A requester transfers when its `x_vld && x_rdy`. All `x_rdy` are 0 when `!out_free`. At most one `x_rdy` is high per cycle.
- On transfer, `ram_vld` is set to 1 and `ram_pld` to the winner's payload. When `ram_rdy && ram_vld` with no new transfer, `ram_vld` is set to 0.
- FSM IDLE:
  - If `starve_cnt == STARVE_MAX` and `ld_vld`, load wins.
  - Otherwise priority is bps > ent > ld.
  - An ent transfer loads `beat_cnt = 1` and moves to LOCK.
- FSM LOCK:
  - Only ent can be granted. `bps_rdy = ld_rdy = 0`.
  - Each ent transfer increments `beat_cnt`.
  - The transfer that makes `REFILL_BEATS` beats moves to IDLE and clears `beat_cnt`.
  - Gaps in `ent_vld` during LOCK keep the lock; other requesters stay blocked.
- `starve_cnt`, width `$clog2(STARVE_MAX+1)`:
  - Cleared on a load transfer or when `!ld_vld`.
  - Otherwise increments each cycle `ld_vld && !ld_rdy`, in either state, saturating at `STARVE_MAX`.
- A saturated count forces the load grant only in IDLE. It never breaks a refill lock; load wins the first free IDLE cycle after LOCK exits.
- `lock_busy = (state == LOCK)`.
- Requester payloads must hold stable while `x_vld && !x_rdy`. The block does not check this.

## Timing
- Reset values: `ram_vld = 0`, `ram_pld = '0`, state IDLE, `beat_cnt = 0`, `starve_cnt = 0`, `lock_busy = 0`.
- Latency: a request accepted in cycle N appears on `ram_vld/ram_pld` in cycle N+1.
- Throughput: one request per cycle while `ram_rdy` stays high.
- `x_rdy` is combinational from `x_vld`, state, `starve_cnt`, `ram_vld` and `ram_rdy`. There is no combinational path from any payload to any ready.
- Asserting `rst_n` mid-burst abandons the lock: the FSM returns to IDLE and `ram_vld` drops immediately. Re-issuing the refill is the MSHR's responsibility.
- When `ram_rdy` is low with `ram_vld` high, `ram_pld` holds and all `x_rdy` are 0.

## Structure
- `pack_data_ram_req_pld` lives in `l1d_package` and is shared with the MSHR and the data RAM.
- Add an FSM state enum `data_ram_sched_state_e` {IDLE, LOCK} to `l1d_package`.
- One sub-module, `l1d_data_ram_out_reg`: a valid/ready pipeline register holding `ram_vld/ram_pld` and producing `out_free`.
- Arbitration, FSM and counters stay in the top.

## Test plan
- **Reset and priority.** Drive `ram_rdy = 1` and raise `bps_vld`, `ent_vld` and `ld_vld` in the same cycle.
  - Required: `bps_rdy = 1` only; `ram_pld == bps_pld` one cycle later; then ent wins and `lock_busy = 1`.
- **Refill lock.** `REFILL_BEATS = 4`; ent beats arrive with one-cycle gaps while `bps_vld` is held high.
  - Required: 4 ent transfers with `bps_rdy = 0` throughout; `bps` is granted the cycle after the 4th beat; `lock_busy` falls with it.
- **Load starvation.** Hold `ld_vld` and `bps_vld` high continuously with `STARVE_MAX = 8`.
  - Required: load is granted exactly on the 9th cycle, `starve_cnt` returns to 0, and bps resumes winning.
- **Backpressure.** Hold `ram_rdy = 0` for 5 cycles with `ram_vld = 1`.
  - Required: `ram_pld` is stable, all `x_rdy = 0`, and `starve_cnt` keeps counting.
  - On `ram_rdy = 1`, the next winner transfers in the same cycle.
- **Starve during lock.** `starve_cnt` saturates mid-refill.
  - Required: the lock completes all 4 beats, then load wins over a pending bps.
- **Reset mid-burst.** Drop `rst_n` after beat 2.
  - Required: `ram_vld = 0`, `lock_busy = 0` and the counters read 0 asynchronously.
  - After release, bps is granted normally.
